// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the Mandelbrot renderer: Q4.12 fixed point,
// the complex-plane origin/step, the escape radius and the engine state encoding.
package mandelbrot_pkg;

    typedef logic signed [15:0] fixed_t;
    typedef logic signed [31:0] wide_t;

    localparam int FRAC_BITS = 12;

    localparam fixed_t RE_MIN = 16'shE000;
    localparam fixed_t IM_MAX = 16'sh1200;
    localparam fixed_t STEP   = 16'sd192;

    localparam logic signed [32:0] ESCAPE_R2 = 33'sd67108864;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ITER  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } eng_state_t;

    // Q8.24 product back to Q4.12; integer overflow wraps silently.
    function automatic fixed_t fx_slice(input wide_t w);
        return w[FRAC_BITS+15:FRAC_BITS];
    endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing: clk/2 pixel clock, horizontal/vertical counters and the
// raw (unpipelined) sync and display-enable decode.
module vga_timing #(
    parameter int H_ACTIVE = 64,
    parameter int H_FP     = 4,
    parameter int H_SYNC   = 8,
    parameter int H_BP     = 4,
    parameter int V_ACTIVE = 48,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 2,
    parameter int H_W      = 7,
    parameter int V_W      = 6
) (
    input  logic           clk,
    input  logic           reset,
    output logic           pix_clk,
    output logic [H_W-1:0] h_cnt,
    output logic [V_W-1:0] v_cnt,
    output logic           hs,
    output logic           vs,
    output logic           blank
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic           pix_clk_r;
    logic [H_W-1:0] h_cnt_r;
    logic [V_W-1:0] v_cnt_r;

    // Pixel clock divider and raster counters; counters step when pix_clk falls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_clk_r <= 1'b0;
            h_cnt_r   <= '0;
            v_cnt_r   <= '0;
        end else begin
            pix_clk_r <= ~pix_clk_r;
            if (pix_clk_r) begin
                if (h_cnt_r == H_W'(H_TOTAL - 1)) begin
                    h_cnt_r <= '0;
                    if (v_cnt_r == V_W'(V_TOTAL - 1)) begin
                        v_cnt_r <= '0;
                    end else begin
                        v_cnt_r <= v_cnt_r + V_W'(1);
                    end
                end else begin
                    h_cnt_r <= h_cnt_r + H_W'(1);
                end
            end
        end
    end

    assign pix_clk = pix_clk_r;
    assign h_cnt   = h_cnt_r;
    assign v_cnt   = v_cnt_r;
    assign hs      = !((h_cnt_r >= H_W'(HS_START)) && (h_cnt_r < H_W'(HS_END)));
    assign vs      = !((v_cnt_r >= V_W'(VS_START)) && (v_cnt_r < V_W'(VS_END)));
    assign blank   = (h_cnt_r < H_W'(H_ACTIVE)) && (v_cnt_r < V_W'(V_ACTIVE));

endmodule

// File: rtl/mandelbrot_set.sv
// Mandelbrot renderer top: iteration engine, escape-count framebuffer and VGA colour output.
// Build option: define MANDEL_GRAYSCALE_EN for a grey palette instead of the colour map.
module mandelbrot_set
    import mandelbrot_pkg::*;
#(
    parameter int H_ACTIVE = 64,
    parameter int V_ACTIVE = 48,
    parameter int H_FP     = 4,
    parameter int H_SYNC   = 8,
    parameter int H_BP     = 4,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 2,
    parameter int MAX_ITER = 32
) (
    input  logic       clk,
    input  logic       reset,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_SYNC,
    output logic       VGA_CLK,
    output logic       VGA_BLANK
);
    localparam int H_W  = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int V_W  = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int NPIX = H_ACTIVE * V_ACTIVE;
    localparam int A_W  = $clog2(NPIX);
    localparam int X_W  = $clog2(H_ACTIVE);
    localparam int Y_W  = $clog2(V_ACTIVE);

    logic [H_W-1:0] h_cnt_s;
    logic [V_W-1:0] v_cnt_s;
    logic           hs_s, vs_s, blank_s, pix_clk_s;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .H_W(H_W), .V_W(V_W)
    ) u_timing (
        .clk     (clk),
        .reset   (reset),
        .pix_clk (pix_clk_s),
        .h_cnt   (h_cnt_s),
        .v_cnt   (v_cnt_s),
        .hs      (hs_s),
        .vs      (vs_s),
        .blank   (blank_s)
    );

    eng_state_t     state_r;
    logic [X_W-1:0] x_r;
    logic [Y_W-1:0] y_r;
    fixed_t         cr_r, ci_r, zr_r, zi_r;
    logic [7:0]     n_r;
    logic           frame_valid_r;

    wide_t             sq_re_s, sq_im_s, cross_s;
    logic signed [32:0] mag_s;
    fixed_t            zr_next_s, zi_next_s, cr_init_s, ci_init_s;
    logic              escape_s;
    logic [A_W-1:0]    wr_addr_s, rd_addr_s;

    // Complex-plane arithmetic for one iteration step and the next pixel's c.
    always_comb begin
        sq_re_s   = wide_t'(zr_r) * wide_t'(zr_r);
        sq_im_s   = wide_t'(zi_r) * wide_t'(zi_r);
        cross_s   = wide_t'(zr_r) * wide_t'(zi_r);
        mag_s     = {sq_re_s[31], sq_re_s} + {sq_im_s[31], sq_im_s};
        escape_s  = (mag_s > ESCAPE_R2) || (n_r == 8'(MAX_ITER));
        zr_next_s = fx_slice(sq_re_s - sq_im_s) + cr_r;
        zi_next_s = fx_slice(cross_s <<< 1) + ci_r;
        cr_init_s = RE_MIN + fixed_t'(x_r) * STEP;
        ci_init_s = IM_MAX - fixed_t'(y_r) * STEP;
        wr_addr_s = A_W'(y_r) * A_W'(H_ACTIVE) + A_W'(x_r);
    end

    // Escape-time engine: one iteration per cycle, pixels in raster order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            x_r           <= '0;
            y_r           <= '0;
            cr_r          <= '0;
            ci_r          <= '0;
            zr_r          <= '0;
            zi_r          <= '0;
            n_r           <= 8'd0;
            frame_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: state_r <= ST_INIT;
                ST_INIT: begin
                    zr_r    <= '0;
                    zi_r    <= '0;
                    n_r     <= 8'd0;
                    cr_r    <= cr_init_s;
                    ci_r    <= ci_init_s;
                    state_r <= ST_ITER;
                end
                ST_ITER: begin
                    if (escape_s) begin
                        state_r <= ST_WRITE;
                    end else begin
                        zr_r <= zr_next_s;
                        zi_r <= zi_next_s;
                        n_r  <= n_r + 8'd1;
                    end
                end
                ST_WRITE: begin
                    if (x_r == X_W'(H_ACTIVE - 1)) begin
                        x_r <= '0;
                        if (y_r == Y_W'(V_ACTIVE - 1)) begin
                            state_r       <= ST_DONE;
                            frame_valid_r <= 1'b1;
                        end else begin
                            y_r     <= y_r + Y_W'(1);
                            state_r <= ST_INIT;
                        end
                    end else begin
                        x_r     <= x_r + X_W'(1);
                        state_r <= ST_INIT;
                    end
                end
                ST_DONE: state_r <= ST_DONE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    logic [7:0] fb_mem [0:NPIX-1];
    logic [7:0] rd_data_r;

    // Display read address; parked at 0 outside the visible area.
    always_comb begin
        if (blank_s) begin
            rd_addr_s = A_W'(v_cnt_s) * A_W'(H_ACTIVE) + A_W'(h_cnt_s);
        end else begin
            rd_addr_s = '0;
        end
    end

    // Framebuffer: engine write port, synchronous display read port.
    always_ff @(posedge clk) begin
        if (state_r == ST_WRITE) begin
            fb_mem[wr_addr_s] <= n_r;
        end
        rd_data_r <= fb_mem[rd_addr_s];
    end

    logic       hs_d_r, vs_d_r, blank_d_r;
    logic [7:0] r_s, g_s, b_s;

    // Colour map on the read data; black outside the picture and inside the set.
    always_comb begin
        r_s = 8'd0;
        g_s = 8'd0;
        b_s = 8'd0;
        if (blank_d_r && frame_valid_r && (rd_data_r != 8'(MAX_ITER))) begin
`ifdef MANDEL_GRAYSCALE_EN
            r_s = {rd_data_r[4:0], 3'b000};
            g_s = {rd_data_r[4:0], 3'b000};
            b_s = {rd_data_r[4:0], 3'b000};
`else
            r_s = {rd_data_r[4:0], 3'b000};
            g_s = {rd_data_r[5:0], 2'b00};
            b_s = ~{rd_data_r[4:0], 3'b000};
`endif
        end else begin
            r_s = 8'd0;
            g_s = 8'd0;
            b_s = 8'd0;
        end
    end

    // Sync/blank follow the same read-then-colour pipe as RGB so they stay aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_d_r    <= 1'b1;
            vs_d_r    <= 1'b1;
            blank_d_r <= 1'b0;
            VGA_HS    <= 1'b1;
            VGA_VS    <= 1'b1;
            VGA_BLANK <= 1'b0;
            VGA_R     <= 8'd0;
            VGA_G     <= 8'd0;
            VGA_B     <= 8'd0;
        end else begin
            hs_d_r    <= hs_s;
            vs_d_r    <= vs_s;
            blank_d_r <= blank_s;
            VGA_HS    <= hs_d_r;
            VGA_VS    <= vs_d_r;
            VGA_BLANK <= blank_d_r;
            VGA_R     <= r_s;
            VGA_G     <= g_s;
            VGA_B     <= b_s;
        end
    end

    assign VGA_CLK  = pix_clk_s;
    assign VGA_SYNC = 1'b0;

endmodule

// File: tb/tb_mandelbrot_set.sv
// Self-checking bench for mandelbrot_set: reset values, VGA timing, rendered frames
// against an escape-time reference model, and a randomly placed mid-frame reset.
module tb_mandelbrot_set;
    localparam int HA   = 64;
    localparam int VA   = 48;
    localparam int NPIX = HA * VA;
    localparam int MAXI = 32;
    localparam int TCLK = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       VGA_HS, VGA_VS, VGA_SYNC, VGA_CLK, VGA_BLANK;
    logic [7:0] VGA_R, VGA_G, VGA_B;

    int tests_run = 0;
    int tests_failed = 0;

    int          ref_n  [NPIX];
    logic [23:0] cap    [NPIX];
    logic [23:0] cap_a  [NPIX];

    mandelbrot_set dut (
        .clk(clk), .reset(reset),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_SYNC(VGA_SYNC), .VGA_CLK(VGA_CLK), .VGA_BLANK(VGA_BLANK)
    );

    always #(TCLK/2) clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sx16(input int v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    // Escape count for one pixel, straight from the Q4.12 iteration rules.
    function automatic int ref_escape(input int x, input int y);
        int cr, ci, zr, zi, n, zr_t, zi_t;
        longint sr, si, sx;
        cr = sx16(-8192 + x * 192);
        ci = sx16(4608 - y * 192);
        zr = 0; zi = 0; n = 0;
        for (int k = 0; k <= MAXI + 1; k++) begin
            sr = longint'(zr) * zr;
            si = longint'(zi) * zi;
            if ((sr + si > 64'sd67108864) || (n == MAXI)) return n;
            sx   = longint'(zr) * zi * 2;
            zr_t = sx16(int'((sr - si) >>> 12) + cr);
            zi_t = sx16(int'(sx >>> 12) + ci);
            zr = zr_t; zi = zi_t; n++;
        end
        return n;
    endfunction

    function automatic logic [23:0] ref_rgb(input int n);
        logic [7:0] nn, r, g, b;
        nn = n[7:0];
        if (n == MAXI) return 24'h000000;
`ifdef MANDEL_GRAYSCALE_EN
        r = {nn[4:0], 3'b000}; g = r; b = r;
`else
        r = {nn[4:0], 3'b000}; g = {nn[5:0], 2'b00}; b = ~{nn[4:0], 3'b000};
`endif
        return {r, g, b};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_hs"}, VGA_HS, 1);
        check_eq({tag, "_vs"}, VGA_VS, 1);
        check_eq({tag, "_blank"}, VGA_BLANK, 0);
        check_eq({tag, "_rgb"}, {VGA_R, VGA_G, VGA_B}, 0);
        check_eq({tag, "_vgaclk"}, VGA_CLK, 0);
    endtask

    task automatic wait_vs_rise(output bit ok);
        int c;
        ok = 1'b0;
        c = 0;
        while (VGA_VS !== 1'b0 && c < 9000) begin @(negedge clk); c++; end
        while (VGA_VS !== 1'b1 && c < 18000) begin @(negedge clk); c++; end
        ok = (c < 18000);
    endtask

    // Walk one frame sample by sample, storing the first sample of each visible pixel.
    task automatic capture_frame(input bit sync_vs, output int first_blank, output int first_hs);
        int cyc, line, px;
        logic pb, ph;
        bit done, ok;
        for (int i = 0; i < NPIX; i++) cap[i] = 24'h5A5A5A;
        first_blank = -1;
        first_hs = -1;
        if (sync_vs) begin
            wait_vs_rise(ok);
            check_eq("vs_sync_wait", ok, 1);
        end
        pb = VGA_BLANK; ph = VGA_HS;
        line = -1; px = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 9000) begin
            @(negedge clk);
            cyc++;
            if (VGA_BLANK && !pb) begin
                line++;
                px = 0;
                if (line == 0) first_blank = cyc;
            end
            if (VGA_BLANK && line >= 0 && line < VA) begin
                if ((px % 2 == 0) && (px / 2 < HA)) cap[line * HA + px / 2] = {VGA_R, VGA_G, VGA_B};
                px++;
            end
            if (!VGA_HS && ph && first_hs < 0) first_hs = cyc;
            if (!VGA_BLANK && pb && line == VA - 1) done = 1'b1;
            pb = VGA_BLANK; ph = VGA_HS;
        end
        check_eq("capture_complete", done, 1);
    endtask

    function automatic int count_nonblack();
        int c = 0;
        for (int i = 0; i < NPIX; i++) if (cap[i] !== 24'h000000) c++;
        return c;
    endfunction

    // One full VS-to-VS period: sync widths, blank runs and line counts.
    task automatic measure_timing();
        int c, frame_cyc, vs_low, bl_rise, bl_run, bl_min, bl_max, hs_fall, hs_run, hs_min, hs_max;
        logic pv, pb, ph;
        bit fell;
        c = 0;
        while (VGA_VS !== 1'b1 && c < 9000) begin @(negedge clk); c++; end
        while (VGA_VS !== 1'b0 && c < 18000) begin @(negedge clk); c++; end
        check_eq("vs_fall_found", c < 18000, 1);
        frame_cyc = 0; vs_low = 0; bl_rise = 0; bl_run = 0; bl_min = 99999; bl_max = 0;
        hs_fall = 0; hs_run = 0; hs_min = 99999; hs_max = 0; fell = 1'b0;
        pv = VGA_VS; pb = VGA_BLANK; ph = VGA_HS;
        while (!fell && frame_cyc < 10000) begin
            @(negedge clk);
            frame_cyc++;
            if (!VGA_VS) vs_low++;
            if (VGA_BLANK && !pb) bl_rise++;
            if (VGA_BLANK) bl_run++;
            else if (bl_run > 0) begin
                if (bl_run < bl_min) bl_min = bl_run;
                if (bl_run > bl_max) bl_max = bl_run;
                bl_run = 0;
            end
            if (!VGA_HS && ph) hs_fall++;
            if (!VGA_HS) hs_run++;
            else if (hs_run > 0) begin
                if (hs_run < hs_min) hs_min = hs_run;
                if (hs_run > hs_max) hs_max = hs_run;
                hs_run = 0;
            end
            if (!VGA_VS && pv) fell = 1'b1;
            pv = VGA_VS; pb = VGA_BLANK; ph = VGA_HS;
        end
        check_eq("frame_clk", frame_cyc, 8640);
        check_eq("vs_low_clk", vs_low, 320);
        check_eq("blank_lines", bl_rise, VA);
        check_eq("blank_run_min", bl_min, 128);
        check_eq("blank_run_max", bl_max, 128);
        check_eq("hs_lines", hs_fall, 54);
        check_eq("hs_low_min", hs_min, 16);
        check_eq("hs_low_max", hs_max, 16);
    endtask

    initial begin
        int fb, fh, mism, idx, total, gap;
        longint t_rel, t_target;
        logic pc;
`ifdef MANDEL_GRAYSCALE_EN
        logic [23:0] px00_exp = 24'h080808;
`else
        logic [23:0] px00_exp = 24'h0804F7;
`endif
        total = 1;
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++) begin
                ref_n[y * HA + x] = ref_escape(x, y);
                total += ref_n[y * HA + x] + 3;
            end

        // Power-on reset held for 50 ns.
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        check_eq("vga_sync_tied", VGA_SYNC, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        t_rel = $time;

        // First frame renders before the engine can finish: all black.
        capture_frame(1'b0, fb, fh);
        check_eq("por_first_blank_clk", fb, 2);
        check_eq("por_first_hs_clk", fh, 138);
        check_eq("frame0_nonblack", count_nonblack(), 0);

        pc = VGA_CLK;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("vga_clk_toggle", VGA_CLK != pc, 1);
            pc = VGA_CLK;
        end

        measure_timing();

        t_target = t_rel + longint'(total + 200) * TCLK;
        while ($time < t_target) @(negedge clk);

        capture_frame(1'b1, fb, fh);
        cap_a = cap;
        mism = 0;
        for (int i = 0; i < NPIX; i++) if (cap_a[i] !== ref_rgb(ref_n[i])) mism++;
        check_eq("frameA_vs_model", mism, 0);
        check_eq("pixel_0_0", cap_a[0], px00_exp);
        check_eq("pixel_42_24", cap_a[24 * HA + 42], 24'h000000);
        for (int i = 0; i < 12; i++) begin
            idx = $urandom_range(NPIX - 1, 0);
            check_eq("pixel_random", cap_a[idx], ref_rgb(ref_n[idx]));
        end

        capture_frame(1'b1, fb, fh);
        mism = 0;
        for (int i = 0; i < NPIX; i++) if (cap[i] !== cap_a[i]) mism++;
        check_eq("frameB_vs_frameA", mism, 0);

        // Reset at a random point in the frame, held for 3 clk.
        gap = $urandom_range(8000, 200);
        repeat (gap) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_outputs("mid_async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_held");
        reset = 1'b1;
        capture_frame(1'b0, fb, fh);
        check_eq("mid_first_blank_clk", fb, 2);
        check_eq("mid_first_hs_clk", fh, 138);
        check_eq("mid_frame_nonblack", count_nonblack(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
